// File: rtl/uc_mc_ctrl_pkg.sv
// uc_pkg: shared types and encodings for the multicycle MIPS control unit.
// State enum, opcodes, datapath mux encodings and the control strobe bundle.
package uc_pkg;

  typedef enum logic [5:0] {
    ST_FETCH   = 6'd0,
    ST_FWAIT   = 6'd1,
    ST_IRLOAD  = 6'd2,
    ST_DECODE  = 6'd3,
    ST_REX     = 6'd4,
    ST_RWB     = 6'd5,
    ST_BRANCH  = 6'd6,
    ST_MADDR   = 6'd7,
    ST_MWR     = 6'd8,
    ST_MRD     = 6'd9,
    ST_MRWAIT  = 6'd10,
    ST_MLOAD   = 6'd11,
    ST_MWB     = 6'd12,
    ST_LUI     = 6'd13,
    ST_JUMP    = 6'd14,
    ST_AEX     = 6'd15,
    ST_AWB     = 6'd16,
    ST_JAL     = 6'd17,
    ST_ILLEGAL = 6'd18,
    ST_BREAK   = 6'd19
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALUOp
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  // ALUSrcB
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // MemtoReg
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;
  localparam logic [1:0] M2R_PC     = 2'b11;

  // RegDst
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Every datapath strobe and mux select driven by the controller
  typedef struct packed {
    logic       pcwrite;
    logic       iord;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       irwrite;
    logic [1:0] pcsource;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic [1:0] regdst;
    logic       awrite;
    logic       bwrite;
    logic       aluoutload;
    logic       mdrload;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/uc_mc_ctrl_wait_cnt.sv
// uc_wait_cnt: memory wait-state counter shared by the fetch and load waits.
// Loaded with the latency, counts down, flags the final wait cycle.
module uc_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; saturate at zero so the count never wraps
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/uc_mc_ctrl.sv
// uc_mc_ctrl: parametrised multicycle MIPS control unit.
// MEM_LAT sets memory wait states (must satisfy MEM_LAT < 2**CNT_W).
// Optional macro UC_JAL_EN adds the JAL instruction; otherwise opcode 03 traps.
module uc_mc_ctrl
  import uc_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       ZeroFlag,
  input  logic       Break,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ALUOutLoad,
  output logic       MDRLoad,
  output logic       Illegal,
  output logic       Halted,
  output logic [5:0] State_out
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t state;
  ctrl_t  c;
  ctrl_t  co;
  logic   cnt_load, cnt_dec, cnt_last;

  assign cnt_load = (state == ST_FETCH) || (state == ST_MRD);
  assign cnt_dec  = (state == ST_FWAIT) || (state == ST_MRWAIT);

  uc_wait_cnt #(.CNT_W(CNT_W)) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT),
    .last     (cnt_last)
  );

  // State register: Break overrides any transition; BREAK/ILLEGAL hold until Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_FETCH;
    end else if (Break) begin
      state <= ST_BREAK;
    end else begin
      case (state)
        ST_FETCH:  state <= (MEM_LAT == 0) ? ST_IRLOAD : ST_FWAIT;
        ST_FWAIT:  if (cnt_last) state <= ST_IRLOAD;
        ST_IRLOAD: state <= ST_DECODE;
        ST_DECODE: begin
          case (Op)
            OP_RTYPE:       state <= ST_REX;
            OP_BEQ, OP_BNE: state <= ST_BRANCH;
            OP_LW, OP_SW:   state <= ST_MADDR;
            OP_LUI:         state <= ST_LUI;
            OP_J:           state <= ST_JUMP;
            OP_ADDI:        state <= ST_AEX;
`ifdef UC_JAL_EN
            OP_JAL:         state <= ST_JAL;
`endif
            default:        state <= ST_ILLEGAL;
          endcase
        end
        ST_REX:     state <= ST_RWB;
        ST_RWB:     state <= ST_FETCH;
        ST_BRANCH:  state <= ST_FETCH;
        ST_MADDR:   state <= (Op == OP_LW) ? ST_MRD : ST_MWR;
        ST_MWR:     state <= ST_FETCH;
        ST_MRD:     state <= (MEM_LAT == 0) ? ST_MLOAD : ST_MRWAIT;
        ST_MRWAIT:  if (cnt_last) state <= ST_MLOAD;
        ST_MLOAD:   state <= ST_MWB;
        ST_MWB:     state <= ST_FETCH;
        ST_LUI:     state <= ST_FETCH;
        ST_JUMP:    state <= ST_FETCH;
        ST_AEX:     state <= ST_AWB;
        ST_AWB:     state <= ST_FETCH;
`ifdef UC_JAL_EN
        ST_JAL:     state <= ST_FETCH;
`endif
        ST_BREAK:   state <= ST_BREAK;
        default:    state <= ST_ILLEGAL;
      endcase
    end
  end

  // Moore decode of strobes; branch PCWrite alone looks at ZeroFlag/Op
  always_comb begin
    c = '0;
    case (state)
      ST_FETCH:   begin c.alusrcb = SRCB_4; c.aluoutload = 1'b1; end
      ST_FWAIT:   c.iord = 1'b0;
      ST_IRLOAD:  begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.pcsource = PCSRC_ALUOUT; end
      ST_DECODE:  begin
        c.awrite = 1'b1; c.bwrite = 1'b1;
        c.alusrcb = SRCB_IMMSH; c.aluoutload = 1'b1;
      end
      ST_REX:     begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; c.aluoutload = 1'b1; end
      ST_RWB:     begin c.regwrite = 1'b1; c.regdst = DST_RD; end
      ST_BRANCH:  begin
        c.alusrca  = 1'b1;
        c.aluop    = ALU_SUB;
        c.pcsource = PCSRC_ALUOUT;
        c.pcwrite  = ZeroFlag ^ (Op == OP_BNE);
      end
      ST_MADDR:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluoutload = 1'b1; end
      ST_MWR:     begin c.iord = 1'b1; c.memwrite = 1'b1; end
      ST_MRD:     c.iord = 1'b1;
      ST_MRWAIT:  c.iord = 1'b1;
      ST_MLOAD:   begin c.iord = 1'b1; c.mdrload = 1'b1; end
      ST_MWB:     begin c.memtoreg = M2R_MDR; c.regwrite = 1'b1; end
      ST_LUI:     begin c.memtoreg = M2R_LUI; c.regwrite = 1'b1; end
      ST_JUMP:    begin c.pcwrite = 1'b1; c.pcsource = PCSRC_JUMP; end
      ST_AEX:     begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluoutload = 1'b1; end
      ST_AWB:     begin c.regwrite = 1'b1; c.regdst = DST_RT; end
`ifdef UC_JAL_EN
      // PC already holds PC+4 from IRLOAD, so $31 gets the return address
      ST_JAL:     begin
        c.pcwrite = 1'b1; c.pcsource = PCSRC_JUMP;
        c.regwrite = 1'b1; c.regdst = DST_RA; c.memtoreg = M2R_PC;
      end
`endif
      ST_ILLEGAL: c.illegal = 1'b1;
      ST_BREAK:   c.halted = 1'b1;
      default:    c = '0;
    endcase
  end

  // Keep every strobe quiet while Reset is held, even though state reads FETCH
  assign co = Reset ? '0 : c;

  assign PCWrite    = co.pcwrite;
  assign IorD       = co.iord;
  assign MemWrite   = co.memwrite;
  assign MemtoReg   = co.memtoreg;
  assign IRWrite    = co.irwrite;
  assign PCSource   = co.pcsource;
  assign ALUOp      = co.aluop;
  assign ALUSrcA    = co.alusrca;
  assign ALUSrcB    = co.alusrcb;
  assign RegWrite   = co.regwrite;
  assign RegDst     = co.regdst;
  assign AWrite     = co.awrite;
  assign BWrite     = co.bwrite;
  assign ALUOutLoad = co.aluoutload;
  assign MDRLoad    = co.mdrload;
  assign Illegal    = co.illegal;
  assign Halted     = co.halted;
  assign State_out  = state;

endmodule

// File: tb/tb_uc_mc_ctrl.sv
// tb_uc_mc_ctrl: scoreboard bench for uc_mc_ctrl. A reference model expands each
// instruction into its per-cycle strobe pattern; a monitor compares every cycle.
module tb_uc_mc_ctrl;
  import uc_pkg::*;

  localparam int LAT = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = 6'h00;
  logic       ZeroFlag = 1'b0;
  logic       Break = 1'b0;
  logic       PCWrite, IorD, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic       AWrite, BWrite, ALUOutLoad, MDRLoad, Illegal, Halted;
  logic [1:0] MemtoReg, PCSource, ALUSrcB, RegDst;
  logic [2:0] ALUOp;
  logic [5:0] State_out;

  uc_mc_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .ZeroFlag(ZeroFlag), .Break(Break),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegDst(RegDst), .AWrite(AWrite),
    .BWrite(BWrite), .ALUOutLoad(ALUOutLoad), .MDRLoad(MDRLoad),
    .Illegal(Illegal), .Halted(Halted), .State_out(State_out)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic pcw, iord, memw; logic [1:0] m2r; logic irw; logic [1:0] pcsrc;
    logic [2:0] aluop; logic srca; logic [1:0] srcb; logic regw; logic [1:0] dst;
    logic aw, bw, aol, mdr, ill, hlt;
  } vec_t;

  vec_t  expq[$];
  string tagq[$];
  int    n_tests = 0, n_fail = 0, pushed = 0;
  vec_t  m_e, m_a;
  string m_t;

  function automatic vec_t actual();
    return {PCWrite, IorD, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcA,
            ALUSrcB, RegWrite, RegDst, AWrite, BWrite, ALUOutLoad, MDRLoad,
            Illegal, Halted};
  endfunction

  task automatic push(input vec_t e, input string t);
    expq.push_back(e); tagq.push_back(t); pushed++;
  endtask

  // Common front half of every instruction: fetch, LAT waits, IR load, decode
  task automatic front();
    vec_t e;
    e = '0; e.srcb = 2'b01; e.aol = 1'b1; push(e, "FETCH");
    for (int i = 0; i < LAT; i++) begin e = '0; push(e, "FWAIT"); end
    e = '0; e.irw = 1'b1; e.pcw = 1'b1; e.pcsrc = 2'b01; push(e, "IRLOAD");
    e = '0; e.aw = 1'b1; e.bw = 1'b1; e.srcb = 2'b11; e.aol = 1'b1; push(e, "DECODE");
  endtask

  task automatic illegal_tail(input int n);
    vec_t e;
    for (int i = 0; i < n; i++) begin e = '0; e.ill = 1'b1; push(e, "ILLEGAL"); end
  endtask

  // Execution half, straight from the per-instruction strobe table
  task automatic back(input logic [5:0] op, input logic z);
    vec_t e;
    e = '0;
    case (op)
      6'h00: begin
        e.srca = 1; e.aluop = 3'b010; e.aol = 1; push(e, "REX");
        e = '0; e.regw = 1; e.dst = 2'b01; push(e, "RWB");
      end
      6'h04, 6'h05: begin
        e.srca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01;
        e.pcw = (op == 6'h04) ? z : !z; push(e, "BRANCH");
      end
      6'h23: begin
        e.srca = 1; e.srcb = 2'b10; e.aol = 1; push(e, "MADDR");
        e = '0; e.iord = 1; push(e, "MRD");
        for (int i = 0; i < LAT; i++) push(e, "MRWAIT");
        e.mdr = 1; push(e, "MLOAD");
        e = '0; e.m2r = 2'b01; e.regw = 1; push(e, "MWB");
      end
      6'h2B: begin
        e.srca = 1; e.srcb = 2'b10; e.aol = 1; push(e, "MADDR");
        e = '0; e.iord = 1; e.memw = 1; push(e, "MWR");
      end
      6'h0F: begin e.m2r = 2'b10; e.regw = 1; push(e, "LUI"); end
      6'h02: begin e.pcw = 1; e.pcsrc = 2'b10; push(e, "JUMP"); end
      6'h08: begin
        e.srca = 1; e.srcb = 2'b10; e.aol = 1; push(e, "AEX");
        e = '0; e.regw = 1; e.dst = 2'b00; push(e, "AWB");
      end
`ifdef UC_JAL_EN
      6'h03: begin
        e.pcw = 1; e.pcsrc = 2'b10; e.regw = 1; e.dst = 2'b10; e.m2r = 2'b11;
        push(e, "JAL");
      end
`endif
      default: illegal_tail(20);
    endcase
  endtask

  // Called one tick after a rising edge that starts a FETCH cycle
  task automatic run_instr(input logic [5:0] op, input logic z);
    pushed = 0; Op = op; ZeroFlag = z;
    front(); back(op, z);
    repeat (pushed) @(posedge Clk);
    #1;
  endtask

  // Assert reset, check quiet outputs and FETCH, then release into FETCH
  task automatic reset_chk(input string t);
    Reset = 1'b1; Break = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (actual() !== '0 || State_out !== ST_FETCH) begin
      n_fail++;
      $display("FAIL %s: strobes=%h state=%0d, want strobes=0 state=%0d",
               t, actual(), State_out, ST_FETCH);
    end
    @(posedge Clk); #1 Reset = 1'b0;
  endtask

  // Monitor: one expected vector per cycle while the queue is non-empty
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset && expq.size() > 0) begin
        m_e = expq.pop_front(); m_t = tagq.pop_front(); m_a = actual();
        n_tests++;
        if (m_a !== m_e) begin
          n_fail++;
          $display("FAIL %s @%0t: got %h want %h (Op=%h Z=%b)",
                   m_t, $time, m_a, m_e, Op, ZeroFlag);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] legal [8];
  logic [5:0] rop;

  initial begin
    vec_t e;
    legal = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02, 6'h08};
    repeat (2) @(posedge Clk);
    #1;
    reset_chk("reset_state");

    // Directed: every instruction class, all three branch cases
    run_instr(6'h00, 1'b0);
    run_instr(6'h04, 1'b1);
    run_instr(6'h05, 1'b1);
    run_instr(6'h05, 1'b0);
    run_instr(6'h04, 1'b0);
    run_instr(6'h23, 1'b0);
    run_instr(6'h2B, 1'b1);
    run_instr(6'h0F, 1'b0);
    run_instr(6'h02, 1'b0);
    run_instr(6'h08, 1'b1);

    // Random instruction stream
    for (int k = 0; k < 60; k++) begin
      rop = legal[$urandom_range(0, 7)];
`ifdef UC_JAL_EN
      if ($urandom_range(0, 8) == 0) rop = 6'h03;
`endif
      run_instr(rop, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on a load: stop at the edge entering MRWAIT
    pushed = 0; Op = 6'h23; ZeroFlag = 1'b0;
    front();
    e = '0; e.srca = 1; e.srcb = 2'b10; e.aol = 1; push(e, "MADDR");
    e = '0; e.iord = 1; push(e, "MRD");
    repeat (pushed) @(posedge Clk);
    #1;
    reset_chk("reset_mid_mrwait");
    run_instr(6'h00, 1'b0);

    // Break pulse during the first fetch wait cycle
    pushed = 0; Op = legal[$urandom_range(0, 7)];
    e = '0; e.srcb = 2'b01; e.aol = 1; push(e, "FETCH_pre_break");
    e = '0; push(e, "FWAIT_break");
    for (int i = 0; i < 8; i++) begin e = '0; e.hlt = 1; push(e, "HALTED"); end
    @(posedge Clk); #1 Break = 1'b1;
    @(posedge Clk); #1 Break = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    reset_chk("reset_after_break");

    // Unknown opcode traps and stays trapped
    run_instr(6'h3F, 1'b0);
    reset_chk("reset_after_illegal");

    // Op 03: JAL when enabled, otherwise an illegal trap
    run_instr(6'h03, 1'b0);
    reset_chk("reset_after_op03");
    run_instr(6'h2B, 1'b0);

    @(negedge Clk);
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_mc_ctrl.md
Name: uc_mc_ctrl

Overview:
- Parametrised multicycle MIPS control unit; next generation of the fixed-timing controller.
- Memory wait states come from a parameter-driven counter instead of hard-coded delay states.
- Unknown opcodes trap to a sticky ILLEGAL state; Break halts the core.
- Sits between the instruction register and the datapath muxes/registers; drives every datapath strobe.

Parameters:
- MEM_LAT, 2, memory read latency in cycles between address presentation and valid data (0..15).
- CNT_W, 4, width of the wait counter; must satisfy MEM_LAT < 2**CNT_W.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Op  in  6  IR[31:26] opcode; stable from DECODE until return to FETCH.
- ZeroFlag  in  1  ALU zero result.
- Break  in  1  halt request.
- PCWrite  out  1  PC load.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  2  write-data select: 00 ALUOut, 01 MDR, 10 LUI immediate, 11 PC (JAL only).
- IRWrite  out  1  IR load.
- PCSource  out  2  PC source: 01 ALUOut, 10 jump target.
- ALUOp  out  3  ALU op: 000 add, 001 sub, 010 funct.
- ALUSrcA  out  1  ALU A source: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B source: 00 B, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- RegWrite  out  1  register-file write.
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- AWrite, BWrite  out  1 each  A/B register load.
- ALUOutLoad  out  1  ALUOut load.
- MDRLoad  out  1  MDR load.
- Illegal  out  1  high while in ILLEGAL.
- Halted  out  1  high while in BREAK.
- State_out  out  6  current state encoding (combinational copy).

Behaviour:
- Reset async → state FETCH, wait counter = 0.
- Outputs are Moore-decoded from state, except PCWrite in BRANCH. Any strobe not listed for a state is 0; muxes not listed are 0.
- Priority: Reset > Break > normal transition. A sampled Break enters BREAK from any state, including mid-wait. BREAK and ILLEGAL are absorbing until Reset.
- FETCH: ALUSrcB=01, ALUOutLoad=1; counter ← MEM_LAT. Next: FWAIT, or IRLOAD if MEM_LAT=0.
- FWAIT: IorD=0; counter decrements; leaves to IRLOAD when counter reaches 1 (exactly MEM_LAT cycles).
- IRLOAD: IRWrite=1, PCWrite=1, PCSource=01.
- DECODE: AWrite=BWrite=1, ALUSrcB=11, ALUOutLoad=1. Next by Op:
  - 00 → REX
  - 04/05 → BRANCH
  - 23/2B → MADDR
  - 0F → LUI
  - 02 → JUMP
  - 08 → AEX
  - else → ILLEGAL
- REX: ALUSrcA=1, ALUOp=010, ALUOutLoad=1 → RWB.
- RWB: RegWrite=1, RegDst=01 → FETCH.
- BRANCH: ALUSrcA=1, ALUOp=001, PCSource=01; PCWrite = ZeroFlag XOR (Op==05) → FETCH.
- MADDR: ALUSrcA=1, ALUSrcB=10, ALUOutLoad=1 → MRD (Op 23) or MWR (Op 2B).
- MWR: IorD=1, MemWrite=1 → FETCH.
- MRD: IorD=1; counter ← MEM_LAT → MRWAIT, or MLOAD if MEM_LAT=0.
- MRWAIT: IorD=1; counts like FWAIT → MLOAD.
- MLOAD: IorD=1, MDRLoad=1 → MWB.
- MWB: MemtoReg=01, RegWrite=1 → FETCH.
- LUI: MemtoReg=10, RegWrite=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- AEX: ALUSrcA=1, ALUSrcB=10, ALUOutLoad=1 → AWB.
- AWB: RegWrite=1, RegDst=00 → FETCH.
- Cycle counts at MEM_LAT=2: R-type 7, branch 6, SW 7, LW 11, ADDI 7, J 6.
- Counter never wraps: it is loaded only in FETCH/MRD and decremented only in wait states.

Optional Feature:
- Macro UC_JAL_EN.
- Defined: Op 03 decodes to state JAL, which asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11, then → FETCH. $31 receives the already-incremented PC.
- Undefined: Op 03 → ILLEGAL; encodings RegDst=10 and MemtoReg=11 are never driven.

Decomposition:
- Package uc_pkg holds:
  - state enum, 6-bit
  - opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_LUI, OP_J, OP_ADDI, OP_JAL
  - ALUOp constants
  - ALUSrcB, PCSource, MemtoReg and RegDst encodings
- Sub-module uc_wait_cnt (load/decrement/last flag, width CNT_W) is shared by both wait states.

Test Plan:
- Reset asserted mid-MRWAIT → State_out=FETCH and all strobes 0 within the same cycle; first FETCH asserts ALUOutLoad=1, ALUSrcB=01.
- MEM_LAT=2, Op=00 → IRWrite=1 and PCWrite=1 in cycle 4; RegWrite=1 with RegDst=01 in cycle 7; back to FETCH in cycle 8.
- MEM_LAT=0 and MEM_LAT=5, Op=23 → MDRLoad pulses exactly once, IorD=1 for MEM_LAT+2 consecutive cycles; total instruction length 7 and 17 cycles respectively.
- Op=04 with ZeroFlag=1 → PCWrite=1; Op=05 with ZeroFlag=1 → PCWrite=0; Op=05 with ZeroFlag=0 → PCWrite=1; PCSource=01 in all three.
- Op=3F → Illegal=1 from cycle after DECODE and held over 20 cycles; Break pulse during FWAIT → Halted=1 next cycle, stays until Reset.
- With UC_JAL_EN, Op=03 → one cycle with RegDst=10, MemtoReg=11, RegWrite=1, PCWrite=1; without the macro, Op=03 → Illegal=1.
